// File: rtl/bus_slave_mem_if.sv
// OCP-style processor bus: the master issues WR/RD commands, the slave answers
// reads in order with a DVA/ERR response under master backpressure.
interface Bus_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    MReset_n;
    logic [2:0]              MCmd;
    logic [ADDR_WIDTH-1:0]   MAddr;
    logic [DATA_WIDTH-1:0]   MData;
    logic [DATA_WIDTH/8-1:0] MByteEn;
    logic                    MRespAccept;
    logic                    SCmdAccept;
    logic [1:0]              SResp;
    logic [DATA_WIDTH-1:0]   SData;

    modport master (
        output MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
        input  SCmdAccept, SResp, SData
    );

    modport slave (
        input  MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
        output SCmdAccept, SResp, SData
    );
endinterface

// File: rtl/bus_slave_mem.sv
// On-chip scratch memory bus target: posted byte-enabled writes, reads returned
// in order after a fixed latency through a credit-limited response FIFO.
module bus_slave_mem #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    WORDS      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 2,
    parameter int                    DEPTH      = 4
) (
    input logic  clk,
    input logic  reset,
    Bus_if.slave pbus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0]            CMD_WR    = 3'b001;
    localparam logic [2:0]            CMD_RD    = 3'b010;
    localparam logic [1:0]            RESP_NULL = 2'b00;
    localparam logic [1:0]            RESP_DVA  = 2'b01;
    localparam logic [1:0]            RESP_ERR  = 2'b11;
    localparam logic [ADDR_WIDTH-1:0] WORDS_A   = ADDR_WIDTH'(WORDS);
    localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic [IW-1:0]         widx;
    logic                  in_range;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  pop;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  push_vld;
    logic                  push_err;
    logic [DATA_WIDTH-1:0] push_dat;

    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [DEPTH-1:0]      fifo_err_q;
    logic [DATA_WIDTH-1:0] fifo_dat_q [DEPTH];
    logic                  fifo_nempty;

    // Command decode: only registered state and MReset_n gate acceptance.
    assign pbus.SCmdAccept = (credits_q != DEPTH_C) && pbus.MReset_n && !reset;

    always_comb begin
        offset   = pbus.MAddr - BASE_ADDR;
        idx      = offset >> SHIFT;
        widx     = idx[IW-1:0];
        in_range = (pbus.MAddr >= BASE_ADDR) && (idx < WORDS_A);
        wr_acc   = pbus.SCmdAccept && (pbus.MCmd == CMD_WR);
        rd_acc   = pbus.SCmdAccept && (pbus.MCmd == CMD_RD);
        rd_data  = in_range ? mem[widx] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (pbus.MByteEn[b]) begin
                    mem[widx][b*8 +: 8] <= pbus.MData[b*8 +: 8];
                end
            end
        end
    end

    // Read tag pipeline: LATENCY-1 register stages, the FIFO write is the last edge.
    generate
        if (LATENCY > 1) begin : g_pipe
            logic [LATENCY-2:0]    pvld_q, pvld_d;
            logic [LATENCY-2:0]    perr_q;
            logic [DATA_WIDTH-1:0] pdat_q [LATENCY-1];

            always_comb begin
                pvld_d = '0;
                if (pbus.MReset_n) begin
                    pvld_d[0] = rd_acc;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pvld_d[i] = pvld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pvld_q <= '0;
                end else begin
                    pvld_q <= pvld_d;
                end
            end

            always_ff @(posedge clk) begin
                perr_q[0] <= ~in_range;
                pdat_q[0] <= rd_data;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    perr_q[i] <= perr_q[i-1];
                    pdat_q[i] <= pdat_q[i-1];
                end
            end

            assign push_vld = pvld_q[LATENCY-2];
            assign push_err = perr_q[LATENCY-2];
            assign push_dat = pdat_q[LATENCY-2];
        end else begin : g_direct
            assign push_vld = rd_acc;
            assign push_err = ~in_range;
            assign push_dat = rd_data;
        end
    endgenerate

    assign fifo_nempty = (cnt_q != '0);
    assign pop         = fifo_nempty && pbus.MRespAccept;

    // FIFO bookkeeping and credits; the credit limit keeps pushes from overflowing.
    always_comb begin
        cnt_d     = cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        credits_d = credits_q;
        if (!pbus.MReset_n) begin
            cnt_d     = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            credits_d = '0;
        end else begin
            if (push_vld) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({push_vld, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            case ({rd_acc, pop})
                2'b10:   credits_d = credits_q + CW'(1);
                2'b01:   credits_d = credits_q - CW'(1);
                default: credits_d = credits_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            credits_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) begin
            fifo_err_q[wptr_q] <= push_err;
            fifo_dat_q[wptr_q] <= push_dat;
        end
    end

    assign pbus.SResp = fifo_nempty ? (fifo_err_q[rptr_q] ? RESP_ERR : RESP_DVA) : RESP_NULL;
    assign pbus.SData = fifo_nempty ? fifo_dat_q[rptr_q] : '0;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: a word model predicts every read response,
// which is queued at command accept and compared when the response is popped.
module tb_bus_slave_mem;
    localparam logic [1:0] NUL = 2'b00;
    localparam logic [1:0] DVA = 2'b01;
    localparam logic [1:0] ERR = 2'b11;
    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] WR   = 3'b001;
    localparam logic [2:0] RD   = 3'b010;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t expq [$];
    logic [31:0] model [256];
    int   run_len = 0;
    int   max_run = 0;
    bit   prev_pop = 1'b0;

    Bus_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    bus_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS(256),
        .BASE_ADDR(32'h0), .LATENCY(2), .DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pbus (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every response popped by the master is checked against the queue head.
    always @(negedge clk) begin
        bit   popped;
        exp_t e;
        popped = 1'b0;
        if (!reset && bus.SResp !== NUL && bus.MRespAccept === 1'b1) begin
            popped = 1'b1;
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $error("FAIL unexpected_resp observed=%b required=no response", bus.SResp);
            end else begin
                e = expq.pop_front();
                assert (bus.SResp === e.resp) else begin
                    failures++;
                    $error("FAIL sb_resp observed=%b required=%b", bus.SResp, e.resp);
                end
                checks++;
                assert (bus.SData === e.data) else begin
                    failures++;
                    $error("FAIL sb_data observed=%h required=%h", bus.SData, e.data);
                end
            end
        end
        run_len  = popped ? (prev_pop ? run_len + 1 : 1) : 0;
        prev_pop = popped;
        if (run_len > max_run) max_run = run_len;
    end

    task automatic check_bit(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%b required=%b", tag, obs, req);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h required=%h", tag, obs, req);
        end
    endtask

    // Drive one command (starting just after a rising edge) until accepted, then go idle.
    task automatic issue(input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be, output int waits);
        int   idx;
        bit   acc;
        exp_t e;
        bus.MCmd = cmd; bus.MAddr = addr; bus.MData = data; bus.MByteEn = be;
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits <= 40) begin
            @(negedge clk);
            if (bus.SCmdAccept === 1'b1) acc = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL accept_timeout observed=no accept required=accept addr=%h", addr);
        end
        if (acc) begin
            idx = int'(addr >> 2);
            if (cmd == WR && idx < 256) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            end else if (cmd == RD) begin
                e.resp = (idx < 256) ? DVA : ERR;
                e.data = (idx < 256) ? model[idx] : 32'h0;
                expq.push_back(e);
            end
            @(posedge clk); #1;
        end
        bus.MCmd = IDLE;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        while (bus.SResp === NUL && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (bus.SResp !== NUL) else begin
            failures++;
            $error("FAIL %s_timeout observed=%b required=response", tag, bus.SResp);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expq.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        assert (expq.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain observed=%0d pending required=0", tag, expq.size());
        end
    endtask

    initial begin
        int w;
        bus.MReset_n = 1'b1; bus.MCmd = IDLE; bus.MAddr = '0;
        bus.MData = '0; bus.MByteEn = '0; bus.MRespAccept = 1'b0;

        // Reset values
        @(negedge clk);
        check_bit("rst_accept", bus.SCmdAccept, 1'b0);
        check_bit("rst_resp_null", bus.SResp === NUL, 1'b1);
        check_word("rst_sdata", bus.SData, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_bit("accept_after_rst", bus.SCmdAccept, 1'b1);
        @(posedge clk); #1;

        // Write then read with exact latency
        bus.MRespAccept = 1'b1;
        issue(WR, 32'h10, 32'hDEAD_BEEF, 4'hF, w);
        issue(RD, 32'h10, 32'h0, 4'h0, w);
        @(negedge clk);
        check_bit("lat_not_early", bus.SResp === NUL, 1'b1);
        @(negedge clk);
        check_bit("lat_dva", bus.SResp === DVA, 1'b1);
        check_word("lat_data", bus.SData, 32'hDEAD_BEEF);
        drain("wr_rd");

        // Byte enables
        issue(WR, 32'h10, 32'h1122_3344, 4'h5, w);
        issue(RD, 32'h10, 32'h0, 4'h0, w);
        wait_resp("be");
        check_word("be_data", bus.SData, 32'hDE22_BE44);
        @(posedge clk); #1;
        drain("be");

        // Streaming 8 reads back to back
        for (int i = 0; i < 8; i++) issue(WR, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, w);
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            issue(RD, 32'(i * 4), 32'h0, 4'h0, w);
            checks++;
            assert (w == 0) else begin
                failures++;
                $error("FAIL stream_stall observed=%0d waits required=0", w);
            end
        end
        drain("stream");
        checks++;
        assert (max_run == 8) else begin
            failures++;
            $error("FAIL stream_consecutive observed=%0d required=8", max_run);
        end

        // Out of range
        issue(RD, 32'h400, 32'h0, 4'h0, w);
        wait_resp("oor");
        check_bit("oor_err", bus.SResp === ERR, 1'b1);
        check_word("oor_data", bus.SData, 32'h0);
        @(posedge clk); #1;
        issue(WR, 32'h400, 32'hFFFF_FFFF, 4'hF, w);
        issue(RD, 32'h0, 32'h0, 4'h0, w);
        wait_resp("oor_wr");
        check_word("oor_wr_nochange", bus.SData, 32'hA000_0000);
        @(posedge clk); #1;
        drain("oor");

        // Backpressure: four credits, fifth read stalls, head holds stable
        bus.MRespAccept = 1'b0;
        for (int i = 0; i < 4; i++) issue(RD, 32'(i * 4), 32'h0, 4'h0, w);
        bus.MCmd = RD; bus.MAddr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("bp_no_accept", bus.SCmdAccept, 1'b0);
            check_bit("bp_hold_dva", bus.SResp === DVA, 1'b1);
            check_word("bp_hold_data", bus.SData, expq[0].data);
        end
        @(posedge clk); #1;
        bus.MRespAccept = 1'b1;
        issue(RD, 32'h10, 32'h0, 4'h0, w);
        drain("bp");

        // Soft reset with three reads outstanding
        bus.MRespAccept = 1'b0;
        for (int i = 0; i < 3; i++) issue(RD, 32'(i * 4), 32'h0, 4'h0, w);
        bus.MReset_n = 1'b0;
        @(negedge clk);
        check_bit("soft_no_accept", bus.SCmdAccept, 1'b0);
        @(posedge clk); #1;
        bus.MReset_n = 1'b1;
        expq.delete();
        @(negedge clk);
        check_bit("soft_resp_null", bus.SResp === NUL, 1'b1);
        check_word("soft_sdata", bus.SData, 32'h0);
        check_bit("soft_credits_zero", dut.credits_q === 3'd0, 1'b1);
        check_bit("soft_accept", bus.SCmdAccept, 1'b1);
        @(posedge clk); #1;
        bus.MRespAccept = 1'b1;
        issue(RD, 32'h10, 32'h0, 4'h0, w);
        wait_resp("soft_keep");
        check_word("soft_mem_kept", bus.SData, 32'hA000_0004);
        @(posedge clk); #1;
        drain("soft");

        // Hard reset mid-stream
        bus.MRespAccept = 1'b0;
        for (int i = 0; i < 3; i++) issue(RD, 32'(i * 4), 32'h0, 4'h0, w);
        bus.MCmd = RD;
        #2;
        check_bit("hard_pre_dva", bus.SResp === DVA, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("hard_async_null", bus.SResp === NUL, 1'b1);
        check_word("hard_async_sdata", bus.SData, 32'h0);
        check_bit("hard_async_accept", bus.SCmdAccept, 1'b0);
        bus.MCmd = IDLE;
        @(posedge clk); #1;
        reset = 1'b0;
        expq.delete();
        @(negedge clk);
        check_bit("hard_accept_back", bus.SCmdAccept, 1'b1);
        check_bit("hard_resp_null", bus.SResp === NUL, 1'b1);
        @(posedge clk); #1;
        bus.MRespAccept = 1'b1;
        issue(WR, 32'h20, 32'h5A5A_0F0F, 4'hF, w);
        issue(RD, 32'h20, 32'h0, 4'h0, w);
        drain("hard");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_slave_mem.md
# bus_slave_mem

- On-chip memory responder (slave) for the processor's OCP-style `Bus_if`: the target end of the bus that vector and PLS masters drive.
- Accepts read/write commands with byte enables and executes writes immediately.
- Returns read data in order after a fixed pipeline latency, honouring master response backpressure.
- Serves as the default target for `Bus_if.master` ports in processor subsystem tests and as a small shared scratch memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bus data width; multiple of 8.
- `ADDR_WIDTH`, 32: bus byte-address width.
- `WORDS`, 256: memory depth in `DATA_WIDTH` words.
- `BASE_ADDR`, 0: byte base address of the memory window; word-aligned.
- `LATENCY`, 2: cycles from read accept to earliest response; ≥1.
- `DEPTH`, 4: maximum outstanding commands; ≥1.

Ports (clock and reset first; bus signals are members of `pbus`, modport `Bus_if.slave`):
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `pbus.MReset_n`  input  1  master soft reset, active-low, sampled synchronously.
- `pbus.MCmd`  input  3  command: 000 IDLE, 001 WR, 010 RD; all other codes are treated as IDLE.
- `pbus.MAddr`  input  ADDR_WIDTH  byte address.
- `pbus.MData`  input  DATA_WIDTH  write data.
- `pbus.MByteEn`  input  DATA_WIDTH/8  write byte enables.
- `pbus.MRespAccept`  input  1  master accepts the current response.
- `pbus.SCmdAccept`  output  1  slave accepts the current command.
- `pbus.SResp`  output  2  response: 00 NULL, 01 DVA, 11 ERR.
- `pbus.SData`  output  DATA_WIDTH  read data.

## Operation
- **Acceptance.** A command is accepted in a cycle when `MCmd` is WR or RD and `SCmdAccept`=1.
  - `SCmdAccept` = (`credits` != `DEPTH`) and `MReset_n`, decoded from registered state only.
- **Index decode.** `idx` = (`MAddr` − `BASE_ADDR`) >> log2(`DATA_WIDTH`/8). The low address bits are ignored.
  - The address is in range iff `MAddr` ≥ `BASE_ADDR` and `idx` < `WORDS`.
- **Writes.**
  - Posted: no response is returned, and a write does not consume a credit.
  - At the accept edge, byte lanes with `MByteEn`=1 are written; the remaining lanes are unchanged.
  - An out-of-range write is silently dropped.
- **Reads.**
  - At the accept edge the memory word is sampled and a tag {data, err} enters a `LATENCY`-stage shift pipeline. `credits` increments.
  - An out-of-range read yields err=1 and data=0.
  - On exit from the pipeline, the tag is pushed into a response FIFO of `DEPTH` entries.
- **Response.**
  - When the FIFO is non-empty, its head drives `SResp` (01 DVA, or 11 ERR when err=1) and `SData`.
  - When the FIFO is empty, `SResp`=00 and `SData`=0.
  - A pop occurs when `SResp`≠00 and `MRespAccept`=1; `credits` decrements on pop.
  - A simultaneous read accept and pop leaves `credits` unchanged.
  - The credit limit guarantees the FIFO never overflows; no overflow handling is needed.
- **Ordering.** Responses return strictly in accept order. A read accepted after a write to the same word returns the written data.
- **Soft reset (`MReset_n`=0).**
  - The next edge clears the pipeline, the FIFO and `credits`.
  - Memory contents are preserved.
  - While `MReset_n`=0, `SCmdAccept`=0.
- **Hard reset (`reset`).**
  - Clears the pipeline, the FIFO and `credits` asynchronously. This applies even mid-burst; responses in flight are discarded.
  - Memory contents are undefined after reset; no initialisation is performed.

## Timing
- Reset values: `SCmdAccept`=0 while `reset`=1, then 1 from the first cycle after deassertion (given `MReset_n`=1); `SResp`=00; `SData`=0.
- Read accepted at edge t: `SResp`/`SData` are valid from the cycle after edge t+`LATENCY`−1, i.e. `LATENCY` cycles after the command cycle, provided no older response is pending.
- The response holds stable until the pop edge. The next queued response appears in the cycle following the pop, giving a sustained throughput of 1 read per cycle when `MRespAccept`=1.
- At `credits`=`DEPTH`, `SCmdAccept` drops the same cycle the limit is reached; it rises in the cycle after the pop edge.
- Writes complete in 1 cycle with no bubble: back-to-back WR, RD, WR, RD all accept consecutively while credits remain.

## Test plan
- **Write/read.** WR 0x0000_0010 data 0xDEAD_BEEF with byte enable 0xF, then RD 0x10 → DVA, `SData`=0xDEAD_BEEF exactly 2 cycles after the RD accept.
- **Byte enables.** Over the prior word, WR 0x10 data 0x1122_3344 with byte enable 0x5, then RD → `SData`=0xDE22_BE44.
- **Out of range.** RD 0x400 (`WORDS`=256) → ERR with `SData`=0; a WR to 0x400 leaves the memory unchanged.
- **Backpressure.** Hold `MRespAccept`=0 and issue 5 reads. Expect 4 accepts, `SCmdAccept`=0 on the 5th; the first response holds stable. Raising `MRespAccept` drains 4 in-order responses and the 5th read is then accepted.
- **Streaming.** With `MRespAccept`=1, issue 8 back-to-back reads of words 0..7 → 8 consecutive DVA cycles in order, with no `SCmdAccept` stall.
- **Resets.** With 3 reads outstanding, pulse `MReset_n`=0 for 1 cycle → `SResp`=00 and `credits`=0, and earlier-written data still reads back. Repeat with `reset` asserted mid-stream → all outputs return to reset values asynchronously.
